snake_engine: RTL and testbench
===============================

# snake_engine

Parametrised snake movement engine; the successor to the fixed single-map move block. It keeps the snake body as a circular segment buffer of configurable depth and advances it one cell per game tick, with reverse-direction rejection, growth, wall or wrap-around borders, and a sequential self-collision scan. It sits between the mouse-direction logic and point generation/draw. Draw logic reads segments through a dedicated read port.

## Interface
Parameters:
- GRID_W, 32, grid width in cells (≤ 64)
- GRID_H, 24, grid height in cells (≤ 64)
- MAX_LEN, 64, segment buffer depth (power of two, ≥ INIT_LEN)
- INIT_LEN, 3, length after start
- INIT_X, 10, initial head x
- INIT_Y, 12, initial head y
- WRAP, 0, 1 = borders wrap; 0 = border hit kills

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle game-step strobe
- start  in  1  one-cycle pulse that (re)initialises the snake
- dir  in  2  requested direction (snake_pkg direction)
- grow  in  1  sampled with tick; extend by one this step
- head_x  out  6  current head x
- head_y  out  6  current head y
- length  out  $clog2(MAX_LEN+1)  current segment count
- alive  out  1  snake running
- dead_cause  out  2  NONE/WALL/SELF
- busy  out  1  step or init in progress
- step_done  out  1  one-cycle pulse when a step commits
- tick_overrun  out  1  sticky, tick arrived while busy; cleared by start
- rd_idx  in  $clog2(MAX_LEN)  segment index, 0 = head
- rd_x, rd_y  out  6  segment coordinates
- rd_valid  out  1  rd_idx < length

## Operation
- FSM states: IDLE, INIT, RUN, SCAN, COMMIT, DEAD.
- IDLE/DEAD + start → INIT. INIT writes INIT_LEN segments, one per cycle: (INIT_X−INIT_LEN+1+i, INIT_Y), i = 0..INIT_LEN−1. Heading = RIGHT. Then → RUN with alive=1, dead_cause=NONE, length=INIT_LEN.
- start in any other state: ignored.
- RUN + tick: latch grow.
  - Effective dir = dir, unless dir is opposite the current heading; then the current heading is kept.
  - Compute next head.
  - WRAP=1: x wraps modulo GRID_W (0−1 → GRID_W−1), y wraps modulo GRID_H.
  - WRAP=0: an out-of-range next head → DEAD, cause WALL; no buffer write.
- SCAN: compare next head with segments 0..L−1, one per cycle.
  - L = length if grow, else length−1 (the tail vacates).
  - Any match → DEAD, cause SELF; buffer and length unchanged.
- COMMIT: write next head at head_ptr+1 (mod MAX_LEN).
  - If grow and length<MAX_LEN: length+1, tail kept.
  - Otherwise: tail_ptr advances and length is unchanged. grow at MAX_LEN is dropped.
  - Update heading.
- DEAD: alive=0. Holds head/length for display until start.
- tick while busy or in IDLE/DEAD: dropped. If busy, sets tick_overrun.

## Timing
- Reset values:
  - state IDLE, all pointers 0
  - head_x/head_y = INIT_X/INIT_Y
  - length=0, alive=0, dead_cause=NONE, busy=0
  - step_done=0, tick_overrun=0, rd_valid=0, rd_x=rd_y=0
- Reset mid-step aborts without a commit.
- Tick at cycle T:
  - SCAN runs T+1..T+L.
  - COMMIT at T+L+1.
  - step_done, new head_x/head_y and length all visible at T+L+2.
  - busy is high from T+1 to T+L+1.
- L=0 (length 1, no grow): COMMIT at T+1.
- Wall death: alive falls at T+1. Self death: alive falls on the cycle after the matching compare. No step_done on death.
- start at S: busy during S+1..S+INIT_LEN; alive=1 at S+INIT_LEN+1.
- Read port: registered, 1-cycle latency, independent of SCAN. rd_x/rd_y/rd_valid are updated the cycle after rd_idx.
- rd_idx maps to buffer entry head_ptr−rd_idx (mod MAX_LEN).

## Structure
- snake_pkg gains:
  - death_cause typedef (NONE, WALL, SELF)
  - engine state enum
  - opposite(direction) function
- Existing direction typedef is reused.
- Sub-module snake_seg_ram: MAX_LEN×12-bit register array, one write port, two read ports (scan, draw).

## Test plan
- Reset, start, INIT_LEN=3 → after 4 cycles alive=1, length=3, head (10,12); rd_idx 0/1/2 → (10,12)/(9,12)/(8,12).
- RUN, dir=UP, tick → step_done 4 cycles later (L=2), head (10,11), length 3; dir=DOWN next tick is rejected → head (10,10).
- WRAP=0, head at x=31 heading RIGHT, tick → alive=0 at T+1, dead_cause=WALL, head unchanged.
- WRAP=1, head (0,5), dir=LEFT, tick → head (31,5).
- Five grow ticks, then the path UP, LEFT, DOWN → head enters a body cell, dead_cause=SELF. Moving into the vacating tail cell without grow stays alive.
- MAX_LEN=4, grow held on each tick → length saturates at 4. Tick during busy → tick_overrun=1, cleared by start.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: directions, death causes, engine FSM states.
package snake_pkg;

  localparam int unsigned CoordW = 6;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } direction_e;

  typedef enum logic [1:0] {
    CauseNone = 2'd0,
    CauseWall = 2'd1,
    CauseSelf = 2'd2
  } death_cause_e;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StScan,
    StCommit,
    StDead
  } engine_state_e;

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic direction_e opposite(input direction_e d);
    return direction_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Segment buffer: Depth x 12-bit {x, y} register array, one write port,
// asynchronous scan and draw read ports.
module snake_seg_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [11:0]      wdata,
  input  logic [AddrW-1:0] scan_addr,
  output logic [11:0]      scan_data,
  input  logic [AddrW-1:0] draw_addr,
  output logic [11:0]      draw_data
);

  logic [11:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign scan_data = mem[scan_addr];
  assign draw_data = mem[draw_addr];

endmodule

// File: rtl/snake_engine.sv
// Snake movement engine: circular segment buffer, one step per tick with
// reverse rejection, growth, wall/wrap borders and a sequential self-collision scan.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 24,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned INIT_X   = 10,
  parameter int unsigned INIT_Y   = 12,
  parameter int unsigned WRAP     = 0,
  localparam int unsigned LenW    = $clog2(MAX_LEN + 1),
  localparam int unsigned IdxW    = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  direction_e         dir,
  input  logic               grow,
  output logic [5:0]         head_x,
  output logic [5:0]         head_y,
  output logic [LenW-1:0]    length,
  output logic               alive,
  output death_cause_e       dead_cause,
  output logic               busy,
  output logic               step_done,
  output logic               tick_overrun,
  input  logic [IdxW-1:0]    rd_idx,
  output logic [5:0]         rd_x,
  output logic [5:0]         rd_y,
  output logic               rd_valid
);

  localparam logic [CoordW-1:0] InitX0 = CoordW'(INIT_X + 1 - INIT_LEN);
  localparam logic [CoordW-1:0] MaxX   = CoordW'(GRID_W - 1);
  localparam logic [CoordW-1:0] MaxY   = CoordW'(GRID_H - 1);

  engine_state_e     state_q, state_d;
  logic [IdxW-1:0]   head_ptr_q, head_ptr_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [LenW-1:0]   length_q, length_d;
  logic [LenW-1:0]   scan_len_q, scan_len_d;
  logic [CoordW-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [CoordW-1:0] nx_q, nx_d, ny_q, ny_d;
  direction_e        heading_q, heading_d, dir_q, dir_d;
  death_cause_e      cause_q, cause_d;
  logic              alive_q, alive_d, grow_q, grow_d;
  logic              step_done_q, step_done_d, overrun_q, overrun_d;
  logic [CoordW-1:0] rd_x_q, rd_y_q;
  logic              rd_valid_q;

  logic              we;
  logic [IdxW-1:0]   waddr;
  logic [11:0]       wdata;
  logic [11:0]       scan_data, draw_data;
  logic [IdxW-1:0]   scan_addr, draw_addr;

  direction_e        eff_dir;
  logic [CoordW-1:0] cand_x, cand_y;
  logic              border_hit;
  logic [LenW-1:0]   run_scan_len;

  assign scan_addr = head_ptr_q - cnt_q;
  assign draw_addr = head_ptr_q - rd_idx;

  snake_seg_ram #(
    .Depth (MAX_LEN)
  ) u_seg_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .draw_addr (draw_addr),
    .draw_data (draw_data)
  );

  // Next-head candidate; border_hit flags a crossing, cand holds the wrapped cell.
  always_comb begin
    eff_dir    = (dir == opposite(heading_q)) ? heading_q : dir;
    cand_x     = head_x_q;
    cand_y     = head_y_q;
    border_hit = 1'b0;
    unique case (eff_dir)
      DirUp: begin
        if (head_y_q == '0) begin
          border_hit = 1'b1;
          cand_y     = MaxY;
        end else begin
          cand_y = head_y_q - 6'd1;
        end
      end
      DirDown: begin
        if (head_y_q == MaxY) begin
          border_hit = 1'b1;
          cand_y     = '0;
        end else begin
          cand_y = head_y_q + 6'd1;
        end
      end
      DirLeft: begin
        if (head_x_q == '0) begin
          border_hit = 1'b1;
          cand_x     = MaxX;
        end else begin
          cand_x = head_x_q - 6'd1;
        end
      end
      DirRight: begin
        if (head_x_q == MaxX) begin
          border_hit = 1'b1;
          cand_x     = '0;
        end else begin
          cand_x = head_x_q + 6'd1;
        end
      end
    endcase
    // Without growth the tail cell vacates this step, so it is not scanned.
    run_scan_len = grow ? length_q : length_q - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    head_ptr_d  = head_ptr_q;
    cnt_d       = cnt_q;
    length_d    = length_q;
    scan_len_d  = scan_len_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    heading_d   = heading_q;
    dir_d       = dir_q;
    cause_d     = cause_q;
    alive_d     = alive_q;
    grow_d      = grow_q;
    step_done_d = 1'b0;
    overrun_d   = overrun_q;
    we          = 1'b0;
    waddr       = head_ptr_q + 1'b1;
    wdata       = {nx_q, ny_q};

    if (tick && busy) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StDead: begin
        if (start) begin
          state_d    = StInit;
          cnt_d      = '0;
          length_d   = '0;
          head_ptr_d = '0;
          overrun_d  = 1'b0;
        end
      end
      StInit: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = {InitX0 + CoordW'(cnt_q), CoordW'(INIT_Y)};
        if (cnt_q == IdxW'(INIT_LEN - 1)) begin
          state_d    = StRun;
          alive_d    = 1'b1;
          cause_d    = CauseNone;
          length_d   = LenW'(INIT_LEN);
          head_ptr_d = IdxW'(INIT_LEN - 1);
          heading_d  = DirRight;
          head_x_d   = CoordW'(INIT_X);
          head_y_d   = CoordW'(INIT_Y);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (tick) begin
          grow_d     = grow;
          dir_d      = eff_dir;
          nx_d       = cand_x;
          ny_d       = cand_y;
          cnt_d      = '0;
          scan_len_d = run_scan_len;
          if (border_hit && (WRAP == 0)) begin
            state_d = StDead;
            alive_d = 1'b0;
            cause_d = CauseWall;
          end else if (run_scan_len == '0) begin
            state_d = StCommit;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (scan_data == {nx_q, ny_q}) begin
          state_d = StDead;
          alive_d = 1'b0;
          cause_d = CauseSelf;
        end else if (LenW'(cnt_q) == scan_len_q - 1'b1) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        we          = 1'b1;
        head_ptr_d  = head_ptr_q + 1'b1;
        head_x_d    = nx_q;
        head_y_d    = ny_q;
        heading_d   = dir_q;
        step_done_d = 1'b1;
        state_d     = StRun;
        if (grow_q && (length_q < LenW'(MAX_LEN))) begin
          length_d = length_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      head_ptr_q  <= '0;
      cnt_q       <= '0;
      length_q    <= '0;
      scan_len_q  <= '0;
      head_x_q    <= CoordW'(INIT_X);
      head_y_q    <= CoordW'(INIT_Y);
      nx_q        <= '0;
      ny_q        <= '0;
      heading_q   <= DirRight;
      dir_q       <= DirRight;
      cause_q     <= CauseNone;
      alive_q     <= 1'b0;
      grow_q      <= 1'b0;
      step_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_ptr_q  <= head_ptr_d;
      cnt_q       <= cnt_d;
      length_q    <= length_d;
      scan_len_q  <= scan_len_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      heading_q   <= heading_d;
      dir_q       <= dir_d;
      cause_q     <= cause_d;
      alive_q     <= alive_d;
      grow_q      <= grow_d;
      step_done_q <= step_done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Draw read port, registered and independent of the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_x_q     <= draw_data[11:6];
      rd_y_q     <= draw_data[5:0];
      rd_valid_q <= LenW'(rd_idx) < length_q;
    end
  end

  assign busy         = (state_q == StInit) || (state_q == StScan) || (state_q == StCommit);
  assign head_x       = head_x_q;
  assign head_y       = head_y_q;
  assign length       = length_q;
  assign alive        = alive_q;
  assign dead_cause   = cause_q;
  assign step_done    = step_done_q;
  assign tick_overrun = overrun_q;
  assign rd_x         = rd_x_q;
  assign rd_y         = rd_y_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: three configurations (default wall map,
// small wall map at the right border, wrap map) driven from shared inputs.
module tb_snake_engine;
  import snake_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] sel;
  logic       tick, start, grow;
  direction_e dir;
  logic [5:0] rd_idx;

  logic tick_m, tick_a, tick_w, start_m, start_a, start_w;
  assign tick_m  = tick & (sel == 2'd0);
  assign tick_a  = tick & (sel == 2'd1);
  assign tick_w  = tick & (sel == 2'd2);
  assign start_m = start & (sel == 2'd0);
  assign start_a = start & (sel == 2'd1);
  assign start_w = start & (sel == 2'd2);

  logic [5:0]   m_hx, m_hy, m_rx, m_ry, a_hx, a_hy, a_rx, a_ry, w_hx, w_hy, w_rx, w_ry;
  logic [6:0]   m_len, w_len;
  logic [2:0]   a_len;
  logic         m_alive, m_busy, m_done, m_ovr, m_rv;
  logic         a_alive, a_busy, a_done, a_ovr, a_rv;
  logic         w_alive, w_busy, w_done, w_ovr, w_rv;
  death_cause_e m_cause, a_cause, w_cause;

  snake_engine u_main (
    .clk(clk), .rst(rst), .tick(tick_m), .start(start_m), .dir(dir), .grow(grow),
    .head_x(m_hx), .head_y(m_hy), .length(m_len), .alive(m_alive), .dead_cause(m_cause),
    .busy(m_busy), .step_done(m_done), .tick_overrun(m_ovr), .rd_idx(rd_idx),
    .rd_x(m_rx), .rd_y(m_ry), .rd_valid(m_rv)
  );

  snake_engine #(.MAX_LEN(4), .INIT_X(31)) u_alt (
    .clk(clk), .rst(rst), .tick(tick_a), .start(start_a), .dir(dir), .grow(grow),
    .head_x(a_hx), .head_y(a_hy), .length(a_len), .alive(a_alive), .dead_cause(a_cause),
    .busy(a_busy), .step_done(a_done), .tick_overrun(a_ovr), .rd_idx(rd_idx[1:0]),
    .rd_x(a_rx), .rd_y(a_ry), .rd_valid(a_rv)
  );

  snake_engine #(.WRAP(1), .INIT_X(1), .INIT_Y(6), .INIT_LEN(2)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick_w), .start(start_w), .dir(dir), .grow(grow),
    .head_x(w_hx), .head_y(w_hy), .length(w_len), .alive(w_alive), .dead_cause(w_cause),
    .busy(w_busy), .step_done(w_done), .tick_overrun(w_ovr), .rd_idx(rd_idx),
    .rd_x(w_rx), .rd_y(w_ry), .rd_valid(w_rv)
  );

  logic       cur_done, cur_alive;
  logic [5:0] cur_hx, cur_hy;
  always_comb begin
    cur_done  = (sel == 2'd0) ? m_done  : (sel == 2'd1) ? a_done  : w_done;
    cur_alive = (sel == 2'd0) ? m_alive : (sel == 2'd1) ? a_alive : w_alive;
    cur_hx    = (sel == 2'd0) ? m_hx    : (sel == 2'd1) ? a_hx    : w_hx;
    cur_hy    = (sel == 2'd0) ? m_hy    : (sel == 2'd1) ? a_hy    : w_hy;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench in cycle S+1.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the bench in cycle T+1.
  task automatic do_tick(input direction_e d, input logic g);
    dir  = d;
    grow = g;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    grow = 1'b0;
  endtask

  // n = 1 in the current cycle; bounded wait for step_done.
  task automatic wait_done(output int n);
    n = 1;
    while (!cur_done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic step(input string tag, input direction_e d, input logic g, input int lat,
                      input int ex, input int ey);
    int n;
    do_tick(d, g);
    wait_done(n);
    check({tag, " latency"}, n, lat);
    check({tag, " head_x"}, cur_hx, ex);
    check({tag, " head_y"}, cur_hy, ey);
  endtask

  task automatic read_seg(input string tag, input int idx, input int ex, input int ey,
                          input logic ev);
    rd_idx = 6'(idx);
    cyc(1);
    check({tag, " rd_valid"}, m_rv, ev);
    if (ev) begin
      check({tag, " rd_x"}, m_rx, ex);
      check({tag, " rd_y"}, m_ry, ey);
    end
  endtask

  initial begin
    int  n;
    logic saw_done;
    rst = 1'b0; sel = 2'd0; tick = 1'b0; start = 1'b0; grow = 1'b0;
    dir = DirRight; rd_idx = '0;

    // Reset state, observed while reset is held.
    cyc(2);
    check("rst head_x", m_hx, 10);
    check("rst head_y", m_hy, 12);
    check("rst length", m_len, 0);
    check("rst alive", m_alive, 0);
    check("rst cause", m_cause, CauseNone);
    check("rst busy", m_busy, 0);
    check("rst step_done", m_done, 0);
    check("rst overrun", m_ovr, 0);
    check("rst rd_valid", m_rv, 0);
    check("rst rd_x", m_rx, 0);
    check("rst rd_y", m_ry, 0);
    rst = 1'b1;
    cyc(1);

    // Start: busy S+1..S+3, alive at S+4.
    do_start();
    check("init S+1 busy", m_busy, 1);
    check("init S+1 alive", m_alive, 0);
    cyc(2);
    check("init S+3 busy", m_busy, 1);
    check("init S+3 alive", m_alive, 0);
    cyc(1);
    check("init alive", m_alive, 1);
    check("init busy", m_busy, 0);
    check("init length", m_len, 3);
    check("init head_x", m_hx, 10);
    check("init head_y", m_hy, 12);
    read_seg("seg0", 0, 10, 12, 1'b1);
    read_seg("seg1", 1, 9, 12, 1'b1);
    read_seg("seg2", 2, 8, 12, 1'b1);
    read_seg("seg3", 3, 0, 0, 1'b0);

    // Basic moves, reverse rejection.
    step("up", DirUp, 1'b0, 4, 10, 11);
    check("up length", m_len, 3);
    step("down rejected", DirDown, 1'b0, 4, 10, 10);

    // Five grow steps to the right, then a loop back into the body.
    step("grow1", DirRight, 1'b1, 5, 11, 10);
    step("grow2", DirRight, 1'b1, 6, 12, 10);
    step("grow3", DirRight, 1'b1, 7, 13, 10);
    step("grow4", DirRight, 1'b1, 8, 14, 10);
    step("grow5", DirRight, 1'b1, 9, 15, 10);
    check("grown length", m_len, 8);
    step("loop up", DirUp, 1'b0, 9, 15, 9);
    step("loop left", DirLeft, 1'b0, 9, 14, 9);
    do_tick(DirDown, 1'b0);
    n = 1;
    saw_done = 1'b0;
    while (m_alive && n < 40) begin
      saw_done |= m_done;
      @(negedge clk);
      n++;
    end
    saw_done |= m_done;
    check("self death cycle", n, 5);
    check("self cause", m_cause, CauseSelf);
    check("self no step_done", saw_done, 0);
    check("self head_x", m_hx, 14);
    check("self head_y", m_hy, 9);
    check("self length", m_len, 8);
    read_seg("dead seg0", 0, 14, 9, 1'b1);

    // Restart; moving into the vacating tail cell is legal.
    do_start();
    cyc(3);
    check("restart alive", m_alive, 1);
    check("restart length", m_len, 3);
    step("tail grow", DirRight, 1'b1, 5, 11, 12);
    step("tail up", DirUp, 1'b0, 5, 11, 11);
    step("tail left", DirLeft, 1'b0, 5, 10, 11);
    step("tail down", DirDown, 1'b0, 5, 10, 12);
    check("tail alive", m_alive, 1);
    check("tail length", m_len, 4);
    read_seg("tail seg3", 3, 11, 12, 1'b1);

    // MAX_LEN=4 at the right border: saturation, overrun, wall death.
    sel = 2'd1;
    do_start();
    cyc(3);
    check("alt alive", a_alive, 1);
    step("alt grow1", DirUp, 1'b1, 5, 31, 11);
    check("alt len after grow1", a_len, 4);
    dir = DirUp; grow = 1'b1; tick = 1'b1;
    cyc(1);
    cyc(1);
    tick = 1'b0; grow = 1'b0;
    check("alt overrun set", a_ovr, 1);
    wait_done(n);
    check("alt grow2 latency", n, 5);
    check("alt grow2 head_y", a_hy, 10);
    check("alt saturated length", a_len, 4);
    do_tick(DirRight, 1'b0);
    check("wall alive T+1", a_alive, 0);
    check("wall cause", a_cause, CauseWall);
    check("wall head_x", a_hx, 31);
    check("wall head_y", a_hy, 10);
    check("wall overrun sticky", a_ovr, 1);
    do_start();
    check("alt start clears overrun", a_ovr, 0);
    cyc(3);
    check("alt restart alive", a_alive, 1);
    check("alt restart length", a_len, 3);
    check("alt restart cause", a_cause, CauseNone);

    // Wrap map: walk off the left edge.
    sel = 2'd2;
    do_start();
    cyc(2);
    check("wrap alive", w_alive, 1);
    step("wrap up", DirUp, 1'b0, 3, 1, 5);
    step("wrap left", DirLeft, 1'b0, 3, 0, 5);
    step("wrap across", DirLeft, 1'b0, 3, 31, 5);
    check("wrap still alive", w_alive, 1);
    check("wrap length", w_len, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
